instr_sequencer: RTL

//  Fetch/decode/timing sequencer for the 16-bit CPU; producer side of the ALU control interface.

---
 rtl/instr_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Fetch/decode/timing sequencer for the 16-bit CPU (producer side of the ALU control interface).
// Optional interrupt entry is built in when the macro IRQ_SEQ_EN is defined.
module instr_sequencer #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] IRQ_VECTOR = 16'h0004,
    parameter logic [5:0]  MAX_OPCODE = 6'd56
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    input  logic        pc_load,
    input  logic [15:0] pc_next,
    output logic [15:0] instruction,
    output logic [5:0]  encoded_opcode,
    output logic [2:0]  rd_addr,
    output logic [2:0]  rs1_addr,
    output logic [2:0]  rs2_addr,
    output logic        fetch,
    output logic        exec1,
    output logic        exec2,
    output logic        reg_we,
    output logic        reg_we2,
    output logic        status_we,
    output logic [15:0] pc,
    output logic        halted,
`ifdef IRQ_SEQ_EN
    input  logic        irq,
    output logic        irq_ack,
`endif
    output logic        illegal
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC1  = 3'd2,
        ST_EXEC2  = 3'd3,
        ST_WB     = 3'd4,
        ST_IRQ    = 3'd5,
        ST_HALT   = 3'd6,
        ST_TRAP   = 3'd7
    } state_e;

    localparam logic [5:0] OP_STP = 6'd39;

    function automatic logic is_multi(input logic [5:0] op);
        logic r;
        case (op)
            6'd25, 6'd26, 6'd27, 6'd28, 6'd33,
            6'd34, 6'd35, 6'd36, 6'd37, 6'd38: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic wr_reg(input logic [5:0] op);
        return ((op >= 6'd3)  && (op <= 6'd12)) || ((op >= 6'd14) && (op <= 6'd24)) ||
               (op == 6'd27) || ((op >= 6'd29) && (op <= 6'd34)) || (op == 6'd37);
    endfunction

    function automatic logic wr_status(input logic [5:0] op);
        return ((op >= 6'd3)  && (op <= 6'd9))  || ((op >= 6'd13) && (op <= 6'd22)) ||
               ((op >= 6'd29) && (op <= 6'd34)) || ((op >= 6'd41) && (op <= 6'd54));
    endfunction

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        mem_req_q, mem_req_d;
    logic        halted_q, halted_d;
    logic        illegal_q, illegal_d;
    logic [5:0]  opcode_s;
    logic        opc_vis_s;

    assign opcode_s  = ir_q[15:10];
    assign opc_vis_s = (state_q == ST_DECODE) || (state_q == ST_EXEC1) ||
                       (state_q == ST_EXEC2)  || (state_q == ST_WB);

    // Next-state, PC/IR update and fetch-request decision.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        mem_req_d = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // mem_req is registered so an ack arriving before the request is raised is ignored
                if (mem_req_q && mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 16'd1;
                    state_d = ST_DECODE;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            ST_DECODE: begin
                if (opcode_s > MAX_OPCODE) begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end else if (opcode_s == OP_STP) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else begin
                    state_d = ST_EXEC1;
                end
            end
            ST_EXEC1: begin
                if (pc_load) begin
                    pc_d = pc_next;
                end else begin
                    pc_d = pc_q;
                end
                if (is_multi(opcode_s)) begin
                    state_d = ST_EXEC2;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_EXEC2: begin
                if (pc_load) begin
                    pc_d = pc_next;
                end else begin
                    pc_d = pc_q;
                end
                state_d = ST_WB;
            end
            ST_WB: begin
`ifdef IRQ_SEQ_EN
                if (irq) begin
                    state_d = ST_IRQ;
                end else begin
                    state_d   = ST_FETCH;
                    mem_req_d = 1'b1;
                end
`else
                state_d   = ST_FETCH;
                mem_req_d = 1'b1;
`endif
            end
            ST_IRQ: begin
                pc_d      = IRQ_VECTOR;
                halted_d  = 1'b0;
                state_d   = ST_FETCH;
                mem_req_d = 1'b1;
            end
            ST_HALT: begin
`ifdef IRQ_SEQ_EN
                if (irq) begin
                    state_d = ST_IRQ;
                end else begin
                    state_d = ST_HALT;
                end
`else
                state_d = ST_HALT;
`endif
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State, PC, IR and sticky flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 16'h0000;
            mem_req_q <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mem_req_q <= mem_req_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    assign mem_req        = mem_req_q;
    assign fetch          = mem_req_q;
    assign mem_addr       = pc_q;
    assign pc             = pc_q;
    assign instruction    = ir_q;
    assign encoded_opcode = opc_vis_s ? opcode_s : 6'd0;
    assign rd_addr        = ir_q[9:7];
    assign rs1_addr       = ir_q[6:4];
    assign rs2_addr       = ir_q[3:1];
    assign exec1          = (state_q == ST_EXEC1);
    assign exec2          = (state_q == ST_EXEC2);
    assign reg_we         = (state_q == ST_WB) && wr_reg(opcode_s);
    assign reg_we2        = (state_q == ST_WB) && ((opcode_s == 6'd33) || (opcode_s == 6'd34));
    assign status_we      = (state_q == ST_WB) && wr_status(opcode_s);
    assign halted         = halted_q;
    assign illegal        = illegal_q;
`ifdef IRQ_SEQ_EN
    assign irq_ack        = (state_q == ST_IRQ);
`endif

endmodule
